// File: rtl/pattern_pkg.sv
// Shared types, pattern table and word-build helper for the pattern encoder.
package pattern_pkg;

  localparam int unsigned PAT_W  = 8;
  localparam int unsigned WORD_W = 2 * PAT_W;

  typedef logic [1:0] pattern_sel_t;
  typedef logic [2:0] bit_offset_t;

  typedef struct packed {
    pattern_sel_t sel;
    bit_offset_t  offset;
  } pattern_req_t;

  localparam int unsigned REQ_W = $bits(pattern_req_t);

  // Index i lines up with the receiving decoder's pattern_o[i].
  localparam logic [3:0][PAT_W-1:0] PATTERN_TABLE = {8'h0F, 8'hF0, 8'h3C, 8'hC3};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LO   = 1'b1
  } enc_state_e;

  // Two fill bytes with the selected pattern overlaid starting k bits below the MSB.
  function automatic logic [WORD_W-1:0] build_word(input logic [PAT_W-1:0] fill,
                                                    input pattern_sel_t     sel,
                                                    input bit_offset_t      k);
    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] pat;
    mask = 16'hFF00 >> k;
    pat  = {PATTERN_TABLE[sel], 8'h00} >> k;
    return ({fill, fill} & ~mask) | pat;
  endfunction

endpackage

// File: rtl/pattern_encoder_if.sv
// Request handshake and serial byte stream bundle of the pattern encoder.
interface pattern_encoder_if;
  import pattern_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  pattern_sel_t      req_sel_i;
  bit_offset_t       req_offset_i;
  logic [PAT_W-1:0]  stream_o;
  logic              busy_o;

  modport slave (
    input  req_valid_i,
    input  req_sel_i,
    input  req_offset_i,
    output req_ready_o,
    output stream_o,
    output busy_o
  );

  modport master (
    output req_valid_i,
    output req_sel_i,
    output req_offset_i,
    input  req_ready_o,
    input  stream_o,
    input  busy_o
  );
endinterface

// File: rtl/pattern_req_fifo.sv
// Synchronous request FIFO of {sel, offset}; no write-to-read bypass.
module pattern_req_fifo
  import pattern_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  pattern_req_t       wdata_i,
  input  logic               pop_i,
  output pattern_req_t       rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o
);

  pattern_req_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full queue refuses writes even when a pop happens on the same edge.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pattern_encoder.sv
// Serialises queued sync-pattern requests into a fill-padded byte stream, two bytes per pattern.
// Optional PATTERN_ENCODER_COUNT_EN adds a 16-bit count of completed pairs on sent_count_o.
module pattern_encoder
  import pattern_pkg::*;
#(
  parameter logic [7:0]  FILL_BYTE  = 8'h00,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_clk_i,
  pattern_encoder_if.slave   req_if
`ifdef PATTERN_ENCODER_COUNT_EN
  ,
  output logic [15:0]        sent_count_o
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  enc_state_e        state_q, state_d;
  logic [PAT_W-1:0]  stream_q, stream_d;
  logic [PAT_W-1:0]  lo_q, lo_d;
  logic [WORD_W-1:0] word;
  logic              pop;
  pattern_req_t      wr_req;
  pattern_req_t      head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign wr_req.sel    = req_if.req_sel_i;
  assign wr_req.offset = req_if.req_offset_i;

  pattern_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_clk_i),
    .push_i  (req_if.req_valid_i),
    .wdata_i (wr_req),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign req_if.req_ready_o = !fifo_full;
  assign req_if.busy_o      = (fifo_count != '0) || (state_q == ST_LO);
  assign req_if.stream_o    = stream_q;

  // IDLE pops on the very next edge, so queued pairs leave back-to-back.
  always_comb begin
    state_d  = state_q;
    stream_d = FILL_BYTE;
    lo_d     = lo_q;
    pop      = 1'b0;
    word     = build_word(FILL_BYTE, head.sel, head.offset);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          stream_d = word[WORD_W-1:PAT_W];
          lo_d     = word[PAT_W-1:0];
          state_d  = ST_LO;
        end
      end
      ST_LO: begin
        stream_d = lo_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset drops any pending low byte.
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      state_q  <= ST_IDLE;
      stream_q <= FILL_BYTE;
      lo_q     <= FILL_BYTE;
    end else begin
      state_q  <= state_d;
      stream_q <= stream_d;
      lo_q     <= lo_d;
    end
  end

`ifdef PATTERN_ENCODER_COUNT_EN
  logic [15:0] sent_cnt_q, sent_cnt_d;

  // Counts LO->IDLE transitions, wrapping naturally at 16 bits.
  always_comb begin
    sent_cnt_d = sent_cnt_q;
    if (state_q == ST_LO) sent_cnt_d = sent_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_clk_i) sent_cnt_q <= 16'd0;
    else           sent_cnt_q <= sent_cnt_d;
  end

  assign sent_count_o = sent_cnt_q;
`endif

endmodule
